// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and helpers for the register-file writeback arbiter
//
// Purpose : arbiter state encoding and the mod-N index increment used for the
//           round-robin pointer and the lock-release pointer.
// Contents: arb_state_t (IDLE, LOCKED), next_idx(idx, n)

package regfile_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // (idx + 1) mod n without a divider; idx is always in 0..n-1.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority picker for round-robin arbitration
//
// Purpose : purely combinational. Scans req starting at ptr, wrapping mod N,
//           and grants the first requester found.
// Ports   : req     in  N   request vector
//           ptr     in  PW  index with highest priority this cycle
//           gnt     out N   one-hot grant, zero when nothing requests
//           gnt_idx out PW  index of the granted requester (0 when none)
//           any     out 1   some requester was granted

module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-port arbiter and write stage for reg_file
//
// Purpose : N writeback sources compete for the single register-file write
//           port. One beat is granted per cycle, round-robin in IDLE; a
//           requester asserting req_lock keeps the port (LOCKED) until it
//           sends a beat without lock or drops valid. The granted beat is
//           registered onto the reg_file write port one cycle later.
// Option  : REGFILE_ARB_FWD_EN - when defined, a read whose address matches the
//           write currently on the port returns the write data combinationally.
// Ports   : CLK, RST_N              clock (rising), async active-low reset
//           req_valid/req_lock  N   per-requester write pending / keep grant
//           req_addr  N*D, req_data N*W  packed per-requester slices
//           req_ready           N   one-hot or zero, combinational
//           rf_write_en/rf_waddr/rf_wdata  registered write port to reg_file
//           rd_addrA/B          D   core read addresses
//           rf_raddrA/B         D   read addresses passed through to reg_file
//           rf_rdataA/B         W   read data from reg_file
//           rd_dataA/B          W   read data delivered to the core

module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3,
  parameter int N = 3
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_lock,
  input  logic [N*D-1:0] req_addr,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           rf_write_en,
  output logic [D-1:0]   rf_waddr,
  output logic [W-1:0]   rf_wdata,
  input  logic [D-1:0]   rd_addrA,
  input  logic [D-1:0]   rd_addrB,
  output logic [D-1:0]   rf_raddrA,
  output logic [D-1:0]   rf_raddrB,
  input  logic [W-1:0]   rf_rdataA,
  input  logic [W-1:0]   rf_rdataB,
  output logic [W-1:0]   rd_dataA,
  output logic [W-1:0]   rd_dataB
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] lock_owner;

  logic [PW-1:0] owner_next;
  logic [PW-1:0] pick_ptr;
  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_valid;
  logic          arbitrating;
  logic          accept;
  logic [D-1:0]  sel_addr;
  logic [W-1:0]  sel_data;

  assign owner_next  = PW'(next_idx(int'(lock_owner), N));
  assign owner_valid = req_valid[lock_owner];

  // A locked owner that drops valid releases in the same cycle, so the
  // picker runs from the post-release pointer and may grant someone else.
  assign arbitrating = (state == IDLE) || !owner_valid;
  assign pick_ptr    = (state == LOCKED) ? owner_next : rr_ptr;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (pick_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Ready depends only on state and valid; forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (RST_N) begin
      if (arbitrating) req_ready = pick_gnt;
      else             req_ready[lock_owner] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // req_ready is one-hot, so an OR-of-ANDs mux selects the granted beat.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*D +: D];
        sel_data = req_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_owner  <= '0;
      rf_write_en <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      rf_write_en <= accept;
      if (accept) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end

      if (arbitrating) begin
        if (pick_any) begin
          rr_ptr <= PW'(next_idx(int'(pick_idx), N));
          if (req_lock[pick_idx]) begin
            state      <= LOCKED;
            lock_owner <= pick_idx;
          end else begin
            state <= IDLE;
          end
        end else if (state == LOCKED) begin
          // Owner dropped valid and nobody else wanted the port.
          state  <= IDLE;
          rr_ptr <= owner_next;
        end
      end else if (!req_lock[lock_owner]) begin
        // Owner's final beat of the burst.
        state  <= IDLE;
        rr_ptr <= owner_next;
      end
    end
  end

  assign rf_raddrA = rd_addrA;
  assign rf_raddrB = rd_addrB;

`ifdef REGFILE_ARB_FWD_EN
  assign rd_dataA = (rf_write_en && (rd_addrA == rf_waddr)) ? rf_wdata : rf_rdataA;
  assign rd_dataB = (rf_write_en && (rd_addrB == rf_waddr)) ? rf_wdata : rf_rdataB;
`else
  assign rd_dataA = rf_rdataA;
  assign rd_dataB = rf_rdataB;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 3;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N*D-1:0] req_addr = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rf_write_en;
  logic [D-1:0]   rf_waddr;
  logic [W-1:0]   rf_wdata;
  logic [D-1:0]   rd_addrA = '0;
  logic [D-1:0]   rd_addrB = '0;
  logic [D-1:0]   rf_raddrA;
  logic [D-1:0]   rf_raddrB;
  logic [W-1:0]   rf_rdataA;
  logic [W-1:0]   rf_rdataB;
  logic [W-1:0]   rd_dataA;
  logic [W-1:0]   rd_dataB;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.W(W), .D(D), .N(N)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_write_en (rf_write_en),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rd_addrA    (rd_addrA),
    .rd_addrB    (rd_addrB),
    .rf_raddrA   (rf_raddrA),
    .rf_raddrB   (rf_raddrB),
    .rf_rdataA   (rf_rdataA),
    .rf_rdataB   (rf_rdataB),
    .rd_dataA    (rd_dataA),
    .rd_dataB    (rd_dataB)
  );

  // Register file model behind the write port.
  logic [W-1:0] mem [2**D];
  always @(posedge CLK) if (rf_write_en) mem[rf_waddr] <= rf_wdata;
  assign rf_rdataA = mem[rf_raddrA];
  assign rf_rdataB = mem[rf_raddrB];

  typedef struct {
    logic [N-1:0]   valid;
    logic [N-1:0]   lock;
    logic [N*D-1:0] addr;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ready;
    logic           exp_we;
    logic [D-1:0]   exp_waddr;
    logic [W-1:0]   exp_wdata;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic [2:0] l,
                     input logic [8:0] a, input logic [23:0] d,
                     input logic [2:0] r, input logic we,
                     input logic [2:0] wa, input logic [7:0] wd);
    vec_t x;
    x.valid = v; x.lock = l; x.addr = a; x.data = d;
    x.exp_ready = r; x.exp_we = we; x.exp_waddr = wa; x.exp_wdata = wd;
    vecs.push_back(x);
  endtask

  task automatic check_port(input string tag, input logic we, input logic [2:0] wa, input logic [7:0] wd);
    check({tag, ".we"},    32'(rf_write_en), 32'(we));
    check({tag, ".waddr"}, 32'(rf_waddr),    32'(wa));
    check({tag, ".wdata"}, 32'(rf_wdata),    32'(wd));
  endtask

  localparam logic [8:0]  A123 = {3'd3, 3'd2, 3'd1};
  localparam logic [23:0] D123 = {8'h33, 8'h22, 8'h11};

  initial begin
    for (int i = 0; i < 2**D; i++) mem[i] = 8'hF0 | 8'(i);

    // Fairness: all valid from pointer 0.
    add(3'b111, 3'b000, A123, D123, 3'b001, 1'b0, 3'd0, 8'h00);
    add(3'b111, 3'b000, A123, D123, 3'b010, 1'b1, 3'd1, 8'h11);
    add(3'b111, 3'b000, A123, D123, 3'b100, 1'b1, 3'd2, 8'h22);
    add(3'b111, 3'b000, A123, D123, 3'b001, 1'b1, 3'd3, 8'h33);
    add(3'b000, 3'b000, A123, D123, 3'b000, 1'b1, 3'd1, 8'h11);
    add(3'b000, 3'b000, A123, D123, 3'b000, 1'b0, 3'd1, 8'h11);
    // Lock burst by requester 1 (pointer is 1), 0 and 2 waiting.
    add(3'b111, 3'b010, {3'd3, 3'd5, 3'd1}, {8'h33, 8'hA0, 8'h11}, 3'b010, 1'b0, 3'd1, 8'h11);
    add(3'b111, 3'b010, {3'd3, 3'd5, 3'd1}, {8'h33, 8'hA1, 8'h11}, 3'b010, 1'b1, 3'd5, 8'hA0);
    add(3'b111, 3'b000, {3'd3, 3'd5, 3'd1}, {8'h33, 8'hA2, 8'h11}, 3'b010, 1'b1, 3'd5, 8'hA1);
    add(3'b101, 3'b000, A123, D123, 3'b100, 1'b1, 3'd5, 8'hA2);
    add(3'b101, 3'b000, A123, D123, 3'b001, 1'b1, 3'd3, 8'h33);
    add(3'b000, 3'b000, A123, D123, 3'b000, 1'b1, 3'd1, 8'h11);
    // Idle hold: one write addr 4 data 0x5C (pointer is 1).
    add(3'b100, 3'b000, {3'd4, 3'd0, 3'd0}, {8'h5C, 8'h00, 8'h00}, 3'b100, 1'b0, 3'd1, 8'h11);
    add(3'b000, 3'b000, '0, '0, 3'b000, 1'b1, 3'd4, 8'h5C);
    add(3'b000, 3'b000, '0, '0, 3'b000, 1'b0, 3'd4, 8'h5C);
    add(3'b000, 3'b000, '0, '0, 3'b000, 1'b0, 3'd4, 8'h5C);
    // Lock by 2, then 2 drops valid: 0 granted in the same cycle.
    add(3'b100, 3'b100, {3'd4, 3'd0, 3'd0}, {8'h5C, 8'h00, 8'h00}, 3'b100, 1'b0, 3'd4, 8'h5C);
    add(3'b100, 3'b100, {3'd7, 3'd0, 3'd0}, {8'hD1, 8'h00, 8'h00}, 3'b100, 1'b1, 3'd4, 8'h5C);
    add(3'b001, 3'b000, {3'd7, 3'd0, 3'd1}, {8'hD1, 8'h00, 8'h11}, 3'b001, 1'b1, 3'd7, 8'hD1);
    add(3'b000, 3'b000, '0, '0, 3'b000, 1'b1, 3'd1, 8'h11);

    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    req_valid = 3'b111;
    #1;
    check("reset.ready", 32'(req_ready), 32'd0);
    check_port("reset", 1'b0, 3'd0, 8'h00);
    RST_N = 1'b1;

    foreach (vecs[k]) begin
      req_valid = vecs[k].valid;
      req_lock  = vecs[k].lock;
      req_addr  = vecs[k].addr;
      req_data  = vecs[k].data;
      #1;
      check($sformatf("vec%0d.ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      check_port($sformatf("vec%0d", k), vecs[k].exp_we, vecs[k].exp_waddr, vecs[k].exp_wdata);
      @(negedge CLK);
    end

    // Reset mid-burst: requester 2 locks (pointer is 1).
    req_valid = 3'b101; req_lock = 3'b100;
    req_addr = {3'd4, 3'd0, 3'd1}; req_data = {8'h66, 8'h00, 8'h11};
    #1 check("rst_burst.grant", 32'(req_ready), 32'b100);
    @(negedge CLK);
    #1;
    check("rst_burst.held", 32'(req_ready), 32'b100);
    check_port("rst_burst.beat", 1'b1, 3'd4, 8'h66);
    RST_N = 1'b0;
    #1;
    check("rst_burst.ready0", 32'(req_ready), 32'd0);
    check_port("rst_burst.in_reset", 1'b0, 3'd0, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1; req_lock = 3'b000;
    #1 check("rst_burst.lowest", 32'(req_ready), 32'b001);
    @(negedge CLK);

    // Forwarding: accept addr 6 data 0x7E at t.
    req_valid = 3'b001; req_lock = 3'b000;
    req_addr = {3'd0, 3'd0, 3'd6}; req_data = {8'h00, 8'h00, 8'h7E};
    rd_addrA = 3'd6; rd_addrB = 3'd2;
    #1;
    check("fwd.t.ready", 32'(req_ready), 32'b001);
    check("fwd.t.rdA", 32'(rd_dataA), 32'hF6);
    @(negedge CLK);
    req_valid = 3'b000;
    #1;
    check_port("fwd.t1", 1'b1, 3'd6, 8'h7E);
    check("fwd.t1.raddrA", 32'(rf_raddrA), 32'd6);
`ifdef REGFILE_ARB_FWD_EN
    check("fwd.t1.rdA", 32'(rd_dataA), 32'h7E);
`else
    check("fwd.t1.rdA", 32'(rd_dataA), 32'hF6);
`endif
    check("fwd.t1.rdB", 32'(rd_dataB), 32'h22);
    @(negedge CLK);
    #1;
    check("fwd.t2.rdA", 32'(rd_dataA), 32'h7E);
    check("fwd.t2.we", 32'(rf_write_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the processor's register file. Up to N writeback requesters (ALU result, load data, immediate/move unit) compete for the single register-file write port. The block grants one per cycle with round-robin fairness, supports locked multi-beat bursts, and drives the register file's write port from a registered stage. It sits between the execute/memory writeback sources and `reg_file`, and optionally forwards in-flight write data onto the read ports.

## Interface
Parameters:
- `W`, 8: data path width
- `D`, 3: register address width (2**D registers)
- `N`, 3: number of requesters, 2..8

Ports:
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `req_valid`  in  N  requester i has a write pending
- `req_lock`  in  N  requester i asks to keep the grant after this beat
- `req_addr`  in  N*D  packed; slice i is requester i's destination register
- `req_data`  in  N*W  packed; slice i is requester i's write data
- `req_ready`  out  N  one-hot or zero; beat accepted when `req_valid[i] & req_ready[i]`
- `rf_write_en`  out  1  to `reg_file.write_en`
- `rf_waddr`  out  D  to `reg_file.waddr`
- `rf_wdata`  out  W  to `reg_file.data_in`
- `rd_addrA`, `rd_addrB`  in  D  core read addresses; passed to `reg_file.raddrA/B`
- `rf_rdataA`, `rf_rdataB`  in  W  from `reg_file.data_outA/B`
- `rd_dataA`, `rd_dataB`  out  W  read data delivered to the core

## Operation
- State machine, 2 states:
  - `IDLE`: arbitrate with round-robin pointer `rr_ptr`.
  - `LOCKED`: only `lock_owner` may be granted.
- IDLE grant:
  - `req_ready[i]=1` for the first i with `req_valid[i]`, scanning from `rr_ptr` upward, mod N.
  - On accept of i: `rr_ptr <= (i+1) mod N`.
  - If `req_lock[i]=1` on that beat: `lock_owner <= i`, go to LOCKED.
- LOCKED:
  - `req_ready[lock_owner] = req_valid[lock_owner]`; all other ready bits are 0.
  - Owner accepts a beat with `req_lock=0`: release to IDLE, `rr_ptr <= (owner+1) mod N`.
  - Owner deasserts `req_valid`: release to IDLE the same cycle (no beat), `rr_ptr <= (owner+1) mod N`.
- `req_ready` is combinational from state and `req_valid`. It never depends on `req_addr` or `req_data`.
- Write stage: on any accept, `rf_write_en<=1`, `rf_waddr<=addr`, `rf_wdata<=data`. With no accept, `rf_write_en<=0` and addr/data hold their previous values.
- Writes to any address are legal, including 0 and 3'b100. No filtering.
- Read pass-through: `rf_raddrX = rd_addrX`. Without forwarding, `rd_dataX = rf_rdataX`.

## Timing
- Reset values (async on `RST_N=0`):
  - state `IDLE`, `rr_ptr=0`, `lock_owner=0`
  - `rf_write_en=0`, `rf_waddr=0`, `rf_wdata=0`
  - `req_ready=0` while `RST_N=0`
- Reset mid-burst drops the lock. The first post-reset grant is to the lowest valid index.
- Accept at cycle t → `rf_write_en=1` during t+1 → `reg_file` updates at the end of t+1 → visible on `rf_rdata` from t+2.
- Throughput: 1 write per cycle sustained. A locked owner can write every cycle.
- Fairness: with all N valid and no locks, grants cycle 0,1,…,N-1,0…
- An accepted beat is consumed. A requester holds `valid`, `addr` and `data` stable until ready.
- Release on the owner's drop of `valid` takes effect combinationally in that same cycle. Another requester may be granted that cycle using the updated pointer.

## Configuration
- `REGFILE_ARB_FWD_EN` defined:
  - If `rf_write_en=1` and `rd_addrX==rf_waddr`, then `rd_dataX = rf_wdata`; otherwise `rd_dataX = rf_rdataX`.
  - This closes the t+1 read-after-write window.
  - Path is combinational, no extra latency.
- Undefined: no compare logic; `rd_dataX = rf_rdataX`. The core must stall one cycle for RAW hazards.

## Structure
- Package `regfile_arb_pkg`:
  - `arb_state_t` enum {`IDLE`, `LOCKED`}
  - `function next_idx(idx, n)` for mod-N increment
- Sub-module `rr_pick`:
  - Parameter N; inputs `req[N]`, `ptr`; outputs one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational rotate-priority encoder, instantiated once.
- Top holds the state register, pointer/owner registers, write stage and forwarding muxes.

## Test plan
- Reset then fairness: `RST_N` pulse; all 3 valid, addrs 1/2/3, data 0x11/0x22/0x33 held → grants 0,1,2,0 on consecutive cycles; `rf_write_en` high from cycle 2; `rf_waddr` sequence 1,2,3,1.
- Lock burst: requester 1 locks for 3 beats (data 0xA0..0xA2, addr 5) while 0 and 2 are valid → `req_ready` = 3'b010 for 3 cycles, then grant goes to 2, then 0.
- Lock drop and reset mid-burst: requester 2 locked, deasserts valid → same cycle requester 0 granted. Repeat with `RST_N` low mid-burst → outputs zero immediately; after release, lowest valid index is granted.
- Idle hold: single write addr 4 data 0x5C, then no requests → `rf_write_en` 1 for exactly one cycle; `rf_waddr`/`rf_wdata` stay 4/0x5C.
- Forwarding: accept addr 6 data 0x7E at t; `rd_addrA=6` at t+1 → with `REGFILE_ARB_FWD_EN`, `rd_dataA=0x7E` at t+1; without it, old value at t+1 and 0x7E at t+2.
